// File: rtl/l0_skew_buf.sv
// ============================================================================
// l0_skew_buf : multi-lane input FIFO for the array west edge, with lockstep
//               or diagonal-wavefront (skewed) read-out.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module l0_skew_buf #(
  parameter int ROW   = 8,
  parameter int BW    = 4,
  parameter int DEPTH = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [ROW*BW-1:0] in,
  input  logic              rd,
  input  logic              mode,
  output logic [ROW*BW-1:0] out,
  output logic [ROW-1:0]    o_valid,
  output logic [ROW-1:0]    o_empty,
  output logic              o_full,
  output logic              o_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [BW-1:0]     mem_q [ROW][DEPTH];
  // All lanes are written together, so one write pointer serves every lane.
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q [ROW];
  logic [PW-1:0]     rd_ptr_d [ROW];
  logic [ROW-1:0]    rd_en_q, rd_en_d;
  logic [ROW*BW-1:0] out_q, out_d;
  logic [ROW-1:0]    valid_q, valid_d;
  logic              mode_q, mode_d;
  logic [ROW-1:0]    full_w;
  logic [ROW-1:0]    pop_w;
  logic              wr_en;

  always_comb begin
    full_w  = '0;
    o_empty = '0;
    for (int i = 0; i < ROW; i++) begin
      o_empty[i] = (wr_ptr_q == rd_ptr_q[i]);
      full_w[i]  = (wr_ptr_q[AW-1:0] == rd_ptr_q[i][AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[i][AW]);
    end
    o_full  = |full_w;
    o_ready = ~o_full;
    wr_en   = wr & ~o_full;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(wr_en);
    pop_w    = '0;
    valid_d  = '0;
    out_d    = out_q;
    for (int i = 0; i < ROW; i++) begin
      rd_ptr_d[i] = rd_ptr_q[i];
      pop_w[i]    = rd_en_q[i] & ~o_empty[i];
      valid_d[i]  = pop_w[i];
      if (pop_w[i]) begin
        rd_ptr_d[i]       = rd_ptr_q[i] + PW'(1);
        out_d[i*BW +: BW] = mem_q[i][rd_ptr_q[i][AW-1:0]];
      end
    end
  end

  // Mode is only re-sampled once the enable chain is fully drained.
  always_comb begin
    mode_d     = (rd_en_q == '0) ? mode : mode_q;
    rd_en_d    = '0;
    rd_en_d[0] = rd;
    for (int i = 1; i < ROW; i++) begin
      rd_en_d[i] = mode_q ? rd_en_q[i-1] : rd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_en_q  <= '0;
      out_q    <= '0;
      valid_q  <= '0;
      mode_q   <= 1'b0;
      for (int i = 0; i < ROW; i++) rd_ptr_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_en_q  <= rd_en_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      mode_q   <= mode_d;
      for (int i = 0; i < ROW; i++) rd_ptr_q[i] <= rd_ptr_d[i];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < ROW; i++) begin
        mem_q[i][wr_ptr_q[AW-1:0]] <= in[i*BW +: BW];
      end
    end
  end

  assign out     = out_q;
  assign o_valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_l0_skew_buf.sv
// ============================================================================
// tb_l0_skew_buf : directed self-checking bench for l0_skew_buf (8x4, depth 64).
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_l0_skew_buf;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr = 1'b0;
  logic [31:0] in = '0;
  logic        rd = 1'b0;
  logic        mode = 1'b0;
  logic [31:0] out;
  logic [7:0]  o_valid;
  logic [7:0]  o_empty;
  logic        o_full;
  logic        o_ready;

  int total = 0;
  int bad   = 0;

  l0_skew_buf #(.ROW(8), .BW(4), .DEPTH(64)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr      (wr),
    .in      (in),
    .rd      (rd),
    .mode    (mode),
    .out     (out),
    .o_valid (o_valid),
    .o_empty (o_empty),
    .o_full  (o_full),
    .o_ready (o_ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fv(input int p, input int k);
    return 32'(p * 64 + k + 1) * 32'h9E3779B9;
  endfunction

  logic [31:0] sv [3];
  logic [7:0]  vexp [11];
  int          cnt [8];
  logic [31:0] tmp;

  initial begin
    sv[0] = 32'h76543210;
    sv[1] = 32'hFEDCBA98;
    sv[2] = 32'h0F1E2D3C;
    vexp  = '{8'h01, 8'h03, 8'h07, 8'h0E, 8'h1C, 8'h38, 8'h70, 8'hE0, 8'hC0, 8'h80, 8'h00};

    // Reset state
    step(); step();
    chk("rst_empty", 32'(o_empty), 32'hFF);
    chk("rst_full",  32'(o_full),  32'h0);
    chk("rst_ready", 32'(o_ready), 32'h1);
    chk("rst_valid", 32'(o_valid), 32'h0);
    chk("rst_out",   out,          32'h0);

    // Lockstep
    reset = 1'b0;
    wr = 1'b1; in = 32'h76543210; step();
    in = 32'hFEDCBA98; step();
    wr = 1'b0;
    chk("ls_not_empty", 32'(o_empty), 32'h00);
    rd = 1'b1; step();
    step();
    chk("ls_out0",   out,          32'h76543210);
    chk("ls_valid0", 32'(o_valid), 32'hFF);
    rd = 1'b0; step();
    chk("ls_out1",   out,          32'hFEDCBA98);
    chk("ls_valid1", 32'(o_valid), 32'hFF);
    chk("ls_empty",  32'(o_empty), 32'hFF);
    step();
    chk("ls_valid_off", 32'(o_valid), 32'h00);

    // Skewed wavefront
    mode = 1'b1;
    wr = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in = sv[k]; step();
    end
    wr = 1'b0;
    for (int i = 0; i < 8; i++) cnt[i] = 0;
    rd = 1'b1; step();
    for (int j = 0; j < 11; j++) begin
      if (j == 2) rd = 1'b0;
      step();
      chk($sformatf("sk_valid%0d", j), 32'(o_valid), 32'(vexp[j]));
      for (int i = 0; i < 8; i++) begin
        if (vexp[j][i]) begin
          tmp = sv[cnt[i]];
          chk($sformatf("sk_lane%0d_w%0d", i, cnt[i]), 32'(out[i*4 +: 4]), 32'(tmp[i*4 +: 4]));
          cnt[i]++;
        end
      end
    end
    chk("sk_empty", 32'(o_empty), 32'hFF);

    // Mode change while the skew chain is busy
    wr = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in = sv[k]; step();
    end
    wr = 1'b0;
    rd = 1'b1; step();
    rd = 1'b0; mode = 1'b0;
    step();
    chk("mc_valid1", 32'(o_valid), 32'h01);
    for (int j = 1; j < 8; j++) begin
      step();
      chk($sformatf("mc_valid_shift%0d", j), 32'(o_valid), 32'(8'h01 << j));
    end
    step();
    chk("mc_valid_drained", 32'(o_valid), 32'h00);
    rd = 1'b1; step();
    rd = 1'b0; step();
    chk("mc_lockstep_valid", 32'(o_valid), 32'hFF);
    chk("mc_lockstep_out",   out,          sv[1]);
    step();
    chk("mc_valid_off", 32'(o_valid), 32'h00);
    chk("mc_not_empty", 32'(o_empty), 32'h00);

    // Empty read
    reset = 1'b1; step(); step(); reset = 1'b0;
    rd = 1'b1;
    for (int j = 0; j < 3; j++) begin
      step();
      chk($sformatf("er_valid%0d", j), 32'(o_valid), 32'h00);
      chk($sformatf("er_empty%0d", j), 32'(o_empty), 32'hFF);
    end
    rd = 1'b0; step(); step();
    wr = 1'b1; in = 32'h13579BDF; step(); wr = 1'b0;
    chk("er_one_entry", 32'(o_empty), 32'h00);
    rd = 1'b1; step(); rd = 1'b0; step();
    chk("er_out",   out,          32'h13579BDF);
    chk("er_valid", 32'(o_valid), 32'hFF);
    step();
    chk("er_empty_after", 32'(o_empty), 32'hFF);

    // Fill to full, dropped write, drain; second pass exercises pointer wrap
    for (int p = 0; p < 2; p++) begin
      wr = 1'b1;
      for (int k = 0; k < 64; k++) begin
        in = fv(p, k); step();
        if (k == 62) chk($sformatf("fl%0d_not_full63", p), 32'(o_full), 32'h0);
      end
      chk($sformatf("fl%0d_full", p),  32'(o_full),  32'h1);
      chk($sformatf("fl%0d_ready", p), 32'(o_ready), 32'h0);
      in = 32'hDEADBEEF; step();
      wr = 1'b0;
      chk($sformatf("fl%0d_still_full", p), 32'(o_full), 32'h1);
      rd = 1'b1; step();
      for (int k = 0; k < 64; k++) begin
        step();
        chk($sformatf("fl%0d_out%0d", p, k),   out,          fv(p, k));
        chk($sformatf("fl%0d_valid%0d", p, k), 32'(o_valid), 32'hFF);
      end
      rd = 1'b0; step();
      chk($sformatf("fl%0d_over_valid", p), 32'(o_valid), 32'h00);
      chk($sformatf("fl%0d_empty", p),      32'(o_empty), 32'hFF);
      chk($sformatf("fl%0d_ready_back", p), 32'(o_ready), 32'h1);
      step();
    end

    // Reset in the middle of a skewed drain
    mode = 1'b1;
    wr = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in = fv(2, k); step();
    end
    wr = 1'b0;
    rd = 1'b1; step(); step(); step();
    rd = 1'b0; step();
    reset = 1'b1; step(); reset = 1'b0; mode = 1'b0;
    chk("mr_empty", 32'(o_empty), 32'hFF);
    chk("mr_full",  32'(o_full),  32'h0);
    chk("mr_ready", 32'(o_ready), 32'h1);
    chk("mr_valid", 32'(o_valid), 32'h00);
    chk("mr_out",   out,          32'h0);
    for (int j = 0; j < 3; j++) begin
      step();
      chk($sformatf("mr_quiet%0d", j), 32'(o_valid), 32'h00);
    end
    wr = 1'b1; in = 32'hA5C30F69; step(); wr = 1'b0;
    rd = 1'b1; step(); rd = 1'b0; step();
    chk("mr_new_out",   out,          32'hA5C30F69);
    chk("mr_new_valid", 32'(o_valid), 32'hFF);
    step();
    chk("mr_end_valid", 32'(o_valid), 32'h00);
    chk("mr_end_empty", 32'(o_empty), 32'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
